// File: rtl/seg_scan_driver.sv
// Multiplexed 7-segment scanner: dead-time, PWM brightness, frame-shadowed inputs; outputs registered (1 cycle), no backpressure.
// Define SEG_LZB_EN to enable leading-zero blanking of the upper digits.
module seg_scan_driver #(
   parameter int NUM_DIGITS = 4,
   parameter int DIV        = 100000,
   parameter int DEAD       = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [4*NUM_DIGITS-1:0] graphics,
   input  logic [NUM_DIGITS-1:0]   dp,
   input  logic [NUM_DIGITS-1:0]   blank,
   input  logic [3:0]              bright,
   output logic [NUM_DIGITS-1:0]   seg_sel,
   output logic [7:0]              seg,
   output logic                    frame_done
);
   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int AW = CW + 6;
   localparam logic [CW-1:0]         CNT_MAX = CW'(DIV - 1);
   localparam logic [DW-1:0]         DIG_MAX = DW'(NUM_DIGITS - 1);
   localparam logic [AW-1:0]         DEAD_W  = AW'(DEAD);
   localparam logic [AW-1:0]         ON_SPAN = AW'(DIV - DEAD);
   localparam logic [NUM_DIGITS-1:0] SEL_ONE = NUM_DIGITS'(1);

   logic [CW-1:0]           cnt_q, cnt_d;
   logic [DW-1:0]           dig_q, dig_d;
   logic [4*NUM_DIGITS-1:0] sh_gfx_q;
   logic [NUM_DIGITS-1:0]   sh_dp_q, sh_blank_q;
   logic [7:0]              seg_q, seg_d;
   logic [NUM_DIGITS-1:0]   seg_sel_q, seg_sel_d;
   logic                    frame_done_q;
   logic                    tick, wrap;
   logic [3:0]              code;
   logic [7:0]              rom;
   logic                    suppress;
   logic [AW-1:0]           cnt_w, lhs, rhs;
   logic                    on;

   assign tick = (cnt_q == CNT_MAX);
   assign wrap = tick && (dig_q == DIG_MAX);
   assign cnt_d = tick ? '0 : cnt_q + CW'(1);
   assign dig_d = wrap ? '0 : (tick ? dig_q + DW'(1) : dig_q);
   assign code  = sh_gfx_q[{dig_q, 2'b00} +: 4];

   // PWM window: lit fraction of the post-dead-time slot is (bright+1)/16.
   assign cnt_w = AW'(cnt_q);
   assign lhs   = (cnt_w - DEAD_W) << 4;
   assign rhs   = ON_SPAN * (AW'(bright) + AW'(1));
   assign on    = (cnt_w >= DEAD_W) && (lhs < rhs);

`ifdef SEG_LZB_EN
   logic [NUM_DIGITS-1:0] lz;
   always_comb begin
      lz = '0;
      lz[NUM_DIGITS-1] = (sh_gfx_q[4*NUM_DIGITS-1 -: 4] == 4'h0);
      for (int k = NUM_DIGITS - 2; k >= 0; k--)
         lz[k] = lz[k+1] && (sh_gfx_q[4*k +: 4] == 4'h0);
      lz[0] = 1'b0;
   end
   assign suppress = lz[dig_q];
`else
   assign suppress = 1'b0;
`endif

   always_comb begin
      rom = 8'hFF;
      unique case (code)
         4'h0: rom = 8'hC0;
         4'h1: rom = 8'hF9;
         4'h2: rom = 8'hA4;
         4'h3: rom = 8'hB0;
         4'h4: rom = 8'h99;
         4'h5: rom = 8'h92;
         4'h6: rom = 8'h82;
         4'h7: rom = 8'hF8;
         4'h8: rom = 8'h80;
         4'h9: rom = 8'h90;
         4'hA: rom = 8'hAB;
         4'hB: rom = 8'hA1;
         4'hC: rom = 8'hAF;
         4'hD: rom = 8'h88;
         4'hE: rom = 8'h6B;
         4'hF: rom = 8'hFF;
      endcase
   end

   always_comb begin
      seg_d     = 8'hFF;
      seg_sel_d = '1;
      if (on) begin
         seg_sel_d = ~(SEL_ONE << dig_q);
         if (!sh_blank_q[dig_q]) begin
            seg_d[6:0] = suppress ? 7'h7F : rom[6:0];
            seg_d[7]   = (suppress ? 1'b1 : rom[7]) & ~sh_dp_q[dig_q];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q        <= '0;
         dig_q        <= '0;
         sh_gfx_q     <= '1;
         sh_dp_q      <= '0;
         sh_blank_q   <= '1;
         seg_q        <= 8'hFF;
         seg_sel_q    <= '1;
         frame_done_q <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         dig_q        <= dig_d;
         seg_q        <= seg_d;
         seg_sel_q    <= seg_sel_d;
         frame_done_q <= wrap;
         // Shadows load only at the frame boundary so a frame never tears.
         if (wrap) begin
            sh_gfx_q   <= graphics;
            sh_dp_q    <= dp;
            sh_blank_q <= blank;
         end
      end
   end

   assign seg        = seg_q;
   assign seg_sel    = seg_sel_q;
   assign frame_done = frame_done_q;
endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver (4 digits, DIV=8, DEAD=1) against a time-indexed reference model.
module tb_seg_scan_driver;
   localparam int ND   = 4;
   localparam int DIV  = 8;
   localparam int DEAD = 1;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b1;
   logic [15:0] graphics = 16'h1234;
   logic [3:0]  dp       = 4'h0;
   logic [3:0]  blank    = 4'h0;
   logic [3:0]  bright   = 4'hF;
   logic [3:0]  seg_sel;
   logic [7:0]  seg;
   logic        frame_done;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [7:0] seg;
      logic [3:0] sel;
      logic       fd;
   } exp_t;
   exp_t q[$];

   logic [7:0] rom [0:15] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                              8'h80, 8'h90, 8'hAB, 8'hA1, 8'hAF, 8'h88, 8'h6B, 8'hFF};

   seg_scan_driver #(.NUM_DIGITS(ND), .DIV(DIV), .DEAD(DEAD)) dut (
      .clk(clk), .rst_n(rst_n), .graphics(graphics), .dp(dp), .blank(blank),
      .bright(bright), .seg_sel(seg_sel), .seg(seg), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   // Reference: position in the scan is derived from elapsed cycles since reset release.
   int         t;
   logic [3:0] m_code  [ND];
   logic       m_dp    [ND];
   logic       m_blank [ND];

   always @(posedge clk or negedge rst_n) begin
      int   c, d;
      exp_t e;
      logic supp;
      if (!rst_n) begin
         q.delete();
         t = 0;
         for (int k = 0; k < ND; k++) begin
            m_code[k]  = 4'hF;
            m_dp[k]    = 1'b0;
            m_blank[k] = 1'b1;
         end
      end else begin
         c = t % DIV;
         d = (t / DIV) % ND;
         e.seg = 8'hFF;
         e.sel = 4'hF;
         e.fd  = (c == DIV - 1) && (d == ND - 1);
         if (c >= DEAD && (c - DEAD) * 16 < (DIV - DEAD) * (int'(bright) + 1)) begin
            e.sel[d] = 1'b0;
            if (!m_blank[d]) begin
               supp = 1'b0;
`ifdef SEG_LZB_EN
               if (d > 0) begin
                  supp = 1'b1;
                  for (int j = d; j < ND; j++)
                     if (m_code[j] != 4'h0) supp = 1'b0;
               end
`endif
               e.seg = supp ? 8'hFF : rom[m_code[d]];
               if (m_dp[d]) e.seg[7] = 1'b0;
            end
         end
         q.push_back(e);
         if (e.fd) begin
            for (int k = 0; k < ND; k++) begin
               m_code[k]  = graphics[4*k +: 4];
               m_dp[k]    = dp[k];
               m_blank[k] = blank[k];
            end
         end
         t++;
      end
   end

   // Monitor: one registered output word per cycle, compared away from the active edge.
   always @(negedge clk) begin
      exp_t e;
      if (q.size() > 0) begin
         e = q.pop_front();
         checks++;
         if ({seg, seg_sel, frame_done} !== e) begin
            errors++;
            $display("FAIL scan_out at %0t: seg=%h sel=%h fd=%b, required seg=%h sel=%h fd=%b",
                     $time, seg, seg_sel, frame_done, e.seg, e.sel, e.fd);
         end
      end else if (!rst_n) begin
         checks++;
         if ({seg, seg_sel, frame_done} !== {8'hFF, 4'hF, 1'b0}) begin
            errors++;
            $display("FAIL reset_hold at %0t: seg=%h sel=%h fd=%b, required seg=ff sel=f fd=0",
                     $time, seg, seg_sel, frame_done);
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   initial begin
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if ({seg, seg_sel, frame_done} !== {8'hFF, 4'hF, 1'b0}) begin
         errors++;
         $display("FAIL reset_async_init: seg=%h sel=%h fd=%b, required seg=ff sel=f fd=0",
                  seg, seg_sel, frame_done);
      end
      cyc(3);
      rst_n = 1'b1;
      cyc(3 * DIV * ND);

      bright = 4'd7;
      cyc(2 * DIV * ND);
      bright = 4'd0;
      cyc(DIV * ND);
      bright = 4'd15;

      graphics = 16'h1111;
      cyc(DIV * ND + 2 * DIV + 3);
      graphics = 16'h2222;
      cyc(2 * DIV * ND);

      dp = 4'b0001; blank = 4'b0100; graphics = 16'hE000;
      cyc(2 * DIV * ND);

      dp = 4'b0000; blank = 4'b0000; graphics = 16'h0050;
      cyc(2 * DIV * ND + 5);

      // Async reset mid-slot, checked before any clock edge.
      rst_n = 1'b0;
      #1;
      checks++;
      if ({seg, seg_sel, frame_done} !== {8'hFF, 4'hF, 1'b0}) begin
         errors++;
         $display("FAIL reset_async_mid: seg=%h sel=%h fd=%b, required seg=ff sel=f fd=0",
                  seg, seg_sel, frame_done);
      end
      cyc(2);
      rst_n = 1'b1;
      cyc(3 * DIV * ND);

      for (int i = 0; i < 40; i++) begin
         graphics = 16'($urandom);
         dp       = 4'($urandom);
         blank    = 4'($urandom_range(0, 3) == 0 ? $urandom : 0);
         bright   = 4'($urandom);
         if ($urandom_range(0, 3) == 0) graphics[15:8] = 8'h00;
         cyc($urandom_range(1, 40));
      end

      for (int i = 0; i < 200; i++) begin
         bright = 4'($urandom);
         cyc(1);
      end

      cyc(2);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
